fwd_scoreboard_unit: RTL
========================

Name: fwd_scoreboard_unit

Overview:
- Parametrised forwarding and hazard unit for the in-order integer pipeline.
- Keeps a shift-register scoreboard of in-flight destination registers, one entry per post-decode stage.
- Produces a per-read-port forwarding select for the youngest producer.
- Raises a load-use stall until a load's data reaches a forwardable stage.
- Sits beside decode; its selects drive the operand muxes feeding execute.

Parameters:
- NREAD, 2, number of source-operand read ports checked.
- NSTAGE, 3, scoreboard depth; stage 1 is youngest (execute), stage NSTAGE is oldest (writeback).
- LOAD_STAGE, 2, first stage (1..NSTAGE) at which load data may be forwarded.
- REGW, 5, register index width.
- SELW, $clog2(NSTAGE+1), width of one forwarding select (derived, not overridden).

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- issue_valid  in  1  decode presents an instruction.
- issue_wen  in  1  issuing instruction writes a register.
- issue_load  in  1  issuing instruction is a load.
- issue_rd  in  REGW  destination register index.
- rs_addr  in  NREAD*REGW  source register indices; port r occupies bits [r*REGW +: REGW].
- rs_used  in  NREAD  per-port mask; an unused port never forwards or stalls.
- ext_stall  in  1  downstream freeze (e.g. memory wait).
- flush  in  1  kill the issuing instruction and the stage-1 entry.
- fwd_sel  out  NREAD*SELW  per port: 0 = register file, k = forward from stage k.
- hazard_stall  out  1  load-use stall request to fetch/decode.
- issue_accept  out  1  issuing instruction entered stage 1 this cycle.

Behaviour:
- Entry format: {valid, wen, load, rd}. Reset clears every valid bit. Consequently fwd_sel = 0, hazard_stall = 0 and issue_accept = 0 on reset and while nRST is low.
- Match rule, per port r: the youngest stage k with valid & wen & rd == rs_addr[r] & rs_used[r] & rs_addr[r] != 0 wins.
  - fwd_sel[r] = k.
  - No match gives fwd_sel[r] = 0.
  - Register 0 never matches.
- Load-use rule:
  - If the winning entry for any used port has load = 1 and k < LOAD_STAGE, then hazard_stall = 1 and that port's fwd_sel is forced to 0.
  - hazard_stall is forced to 0 when flush = 1 or issue_valid = 0.
- fwd_sel and hazard_stall are combinational from the registered scoreboard and the current inputs (zero-cycle latency).
- issue_accept = issue_valid & !hazard_stall & !ext_stall & !flush.
- Sequential update, priority order:
  1. ext_stall = 1: all stages hold. If flush is also 1, only stage 1's valid clears.
  2. Otherwise stages shift: stage k+1 takes stage k, and stage NSTAGE retires.
  3. Stage 1 loads the issuing entry if issue_accept = 1; otherwise it loads a bubble (valid = 0). This covers hazard_stall, flush and no-issue cycles.
- Multi-cycle stall: a load at stage 1 with LOAD_STAGE = 3 stalls a dependent instruction for exactly 2 cycles, absent ext_stall. ext_stall cycles extend the stall, since stages hold.
- Duplicate writers: the youngest entry wins, so an older writer of the same rd is shadowed.
- Reset mid-operation: all entries are dropped immediately (asynchronous). No partial shift occurs.

Optional Feature:
- Macro: FWD_PERF_EN.
- When defined, add output stall_cnt (32 bits):
  - Saturating count of cycles with hazard_stall = 1.
  - Reset to 0 by nRST.
  - Holds at 32'hFFFF_FFFF on reaching it.
  - Also add output fwd_cnt (32 bits), incremented once per cycle in which any port has fwd_sel != 0 and issue_accept = 1, with the same saturation.
- When undefined, neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- Package fwd_pkg holds:
  - the sb_entry_t struct {valid, wen, load, rd};
  - localparam FWD_REGFILE = 0;
  - the default REGW.
- One sub-module, fwd_port_match, holds the per-port youngest-match priority encoder plus the load-too-young flag. It is instantiated NREAD times via generate.

Test Plan:
- Defaults. Issue ADD rd=5, then next cycle issue with rs0=5, rs_used=01 -> fwd_sel[0]=1, hazard_stall=0; one cycle later, same rs -> fwd_sel[0]=2.
- Issue LW rd=7, then next cycle rs0=7 -> hazard_stall=1 for exactly 1 cycle, issue_accept=0; next cycle fwd_sel[0]=2, issue_accept=1.
- Writers rd=3 at stages 1 and 3, rs1=3 -> fwd_sel[1]=1. rs=0 with an in-flight rd=0 writer -> fwd_sel=0.
- Load at stage 1 with matching rs, ext_stall=1 for 3 cycles -> hazard_stall held 4 cycles total and scoreboard unchanged during ext_stall.
- flush=1 with load at stage 1 and dependent issue -> hazard_stall=0, issue_accept=0; next cycle stage 1 empty and no forward from that load.
- nRST low mid-stream with 3 valid entries -> fwd_sel=0 and hazard_stall=0 immediately. With FWD_PERF_EN, stall_cnt=0.

Source files
------------

// File: rtl/fwd_scoreboard_unit_pkg.sv
// fwd_pkg: shared types and constants for the forwarding/hazard unit.
//   FWD_REGW     default register index width
//   FWD_REGFILE  forwarding select value meaning "read the register file"
//   sb_entry_t   one scoreboard entry {valid, wen, load, rd}
package fwd_pkg;

  localparam int unsigned FWD_REGW    = 5;
  localparam int unsigned FWD_REGFILE = 0;

  typedef struct packed {
    logic                valid;
    logic                wen;
    logic                load;
    logic [FWD_REGW-1:0] rd;
  } sb_entry_t;

endpackage

// File: rtl/fwd_scoreboard_unit_if.sv
// fwd_scoreboard_unit_if: decode-side bundle for the forwarding/hazard unit.
//   master: decode (drives issue/operand info, reads selects and stall)
//   slave : fwd_scoreboard_unit
//   issue_valid/wen/load/rd  issuing instruction
//   rs_addr/rs_used          source operands, port r at [r*REGW +: REGW]
//   ext_stall/flush          pipeline control
//   fwd_sel/hazard_stall/issue_accept  unit results
interface fwd_scoreboard_unit_if
  import fwd_pkg::*;
#(
  parameter int unsigned NREAD = 2,
  parameter int unsigned REGW  = FWD_REGW,
  parameter int unsigned SELW  = 2
);

  logic                  issue_valid;
  logic                  issue_wen;
  logic                  issue_load;
  logic [REGW-1:0]       issue_rd;
  logic [NREAD*REGW-1:0] rs_addr;
  logic [NREAD-1:0]      rs_used;
  logic                  ext_stall;
  logic                  flush;
  logic [NREAD*SELW-1:0] fwd_sel;
  logic                  hazard_stall;
  logic                  issue_accept;

  modport master (
    output issue_valid, issue_wen, issue_load, issue_rd,
    output rs_addr, rs_used, ext_stall, flush,
    input  fwd_sel, hazard_stall, issue_accept
  );

  modport slave (
    input  issue_valid, issue_wen, issue_load, issue_rd,
    input  rs_addr, rs_used, ext_stall, flush,
    output fwd_sel, hazard_stall, issue_accept
  );

endinterface

// File: rtl/fwd_scoreboard_unit_port_match.sv
// fwd_port_match: per-read-port youngest-producer priority encoder.
//   sb        scoreboard, index 0 = stage 1 (youngest)
//   rs, used  source register index and port-enable
//   sel       0 = register file, k = forward from stage k
//   too_young winning producer is a load not yet forwardable (sel forced 0)
module fwd_port_match
  import fwd_pkg::*;
#(
  parameter int unsigned NSTAGE     = 3,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned REGW       = FWD_REGW,
  parameter int unsigned SELW       = 2
) (
  input  sb_entry_t [NSTAGE-1:0] sb,
  input  logic [REGW-1:0]        rs,
  input  logic                   used,
  output logic [SELW-1:0]        sel,
  output logic                   too_young
);

  logic        hit;
  logic        hit_load;
  int unsigned hit_stage;

  always_comb begin
    hit       = 1'b0;
    hit_load  = 1'b0;
    hit_stage = 0;
    // Scan oldest to youngest so a younger match overwrites an older one.
    for (int unsigned i = 0; i < NSTAGE; i++) begin
      if (sb[NSTAGE-1-i].valid && sb[NSTAGE-1-i].wen && (sb[NSTAGE-1-i].rd == rs)) begin
        hit       = 1'b1;
        hit_load  = sb[NSTAGE-1-i].load;
        hit_stage = NSTAGE - i;
      end
    end
    if (!used || (rs == '0)) hit = 1'b0;
    too_young = hit && hit_load && (hit_stage < LOAD_STAGE);
    sel       = (hit && !too_young) ? SELW'(hit_stage) : SELW'(FWD_REGFILE);
  end

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// fwd_scoreboard_unit: forwarding and load-use hazard unit beside decode.
// Keeps a shift-register scoreboard of in-flight writers, one entry per
// post-decode stage (stage 1 = execute ... stage NSTAGE = writeback).
//   CLK, nRST  clock, asynchronous active-low reset
//   bus        fwd_scoreboard_unit_if.slave (issue, operands, control, results)
//   stall_cnt, fwd_cnt  saturating performance counters, present only when
//                       FWD_PERF_EN is defined
// The scoreboard rd field width comes from fwd_pkg::FWD_REGW, so REGW must
// match it.
module fwd_scoreboard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned NREAD      = 2,
  parameter int unsigned NSTAGE     = 3,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned REGW       = FWD_REGW
) (
  input  logic                        CLK,
  input  logic                        nRST,
  fwd_scoreboard_unit_if.slave        bus
`ifdef FWD_PERF_EN
  ,
  output logic [31:0]                 stall_cnt,
  output logic [31:0]                 fwd_cnt
`endif
);

  localparam int unsigned SELW = $clog2(NSTAGE + 1);

  sb_entry_t [NSTAGE-1:0] sb;
  sb_entry_t              stage1_kept;
  sb_entry_t              issue_entry;
  logic [NREAD*SELW-1:0]  sel_all;
  logic [NREAD-1:0]       too_young;
  logic                   hazard;
  logic                   accept;

  for (genvar r = 0; r < NREAD; r++) begin : g_port
    fwd_port_match #(
      .NSTAGE     (NSTAGE),
      .LOAD_STAGE (LOAD_STAGE),
      .REGW       (REGW),
      .SELW       (SELW)
    ) u_match (
      .sb        (sb),
      .rs        (bus.rs_addr[r*REGW +: REGW]),
      .used      (bus.rs_used[r]),
      .sel       (sel_all[r*SELW +: SELW]),
      .too_young (too_young[r])
    );
  end

  assign hazard = (|too_young) && bus.issue_valid && !bus.flush;
  // Gated by nRST so no issue is reported accepted while reset is held.
  assign accept = bus.issue_valid && !hazard && !bus.ext_stall && !bus.flush && nRST;

  assign bus.fwd_sel      = sel_all;
  assign bus.hazard_stall = hazard;
  assign bus.issue_accept = accept;

  // Flush kills the stage-1 entry whether the pipe holds or shifts, so a
  // flushed instruction never becomes visible at stage 2.
  always_comb begin
    stage1_kept = sb[0];
    if (bus.flush) stage1_kept.valid = 1'b0;
  end

  always_comb begin
    issue_entry       = '0;
    issue_entry.valid = 1'b1;
    issue_entry.wen   = bus.issue_wen;
    issue_entry.load  = bus.issue_load;
    issue_entry.rd    = bus.issue_rd;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sb <= '0;
    end else if (bus.ext_stall) begin
      sb[0] <= stage1_kept;
    end else begin
      for (int unsigned k = 1; k < NSTAGE; k++) begin
        if (k == 1) sb[k] <= stage1_kept;
        else        sb[k] <= sb[k-1];
      end
      sb[0] <= accept ? issue_entry : '0;
    end
  end

`ifdef FWD_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (hazard && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (accept && (|sel_all) && (fwd_cnt != '1)) fwd_cnt <= fwd_cnt + 32'd1;
    end
  end
`endif

endmodule
